// File: rtl/cmos_dvp_gen.sv
// OV7670-style DVP transmitter: drives pclk/vsyn/href/data with RGB565 frames of a fixed test pattern.
// Optional macro CMOS_DVP_GEN_FRAME_CNT_EN replaces pixel (0,0) with a 16-bit frame counter.
module cmos_dvp_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP_LINES  = 17,
  parameter int V_FP_LINES  = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en_i,
  output logic       cmos_pclk,
  output logic       cmos_vsyn,
  output logic       cmos_href,
  output logic [7:0] cmos_data,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int LINE_PCLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int H_W        = (LINE_PCLKS > 1) ? $clog2(LINE_PCLKS) : 1;
  localparam int MAX_AB     = (VSYNC_LINES > V_BP_LINES) ? VSYNC_LINES : V_BP_LINES;
  localparam int MAX_CD     = (V_ACTIVE > V_FP_LINES) ? V_ACTIVE : V_FP_LINES;
  localparam int MAX_LINES  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LINE_W     = $clog2(MAX_LINES + 1);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  state_t              state_q, state_nxt;
  logic [H_W-1:0]      h_q, h_nxt;
  logic [LINE_W-1:0]   line_q, line_nxt;
  logic                frame_end;
  logic                href_nxt;
  logic [7:0]          data_nxt;
  logic [9:0]          x_f;
  logic [5:0]          y_f;
  logic [15:0]         pix;

`ifdef CMOS_DVP_GEN_FRAME_CNT_EN
  logic [15:0]         frame_cnt_q;
`endif

  function automatic int state_lines(state_t s);
    case (s)
      VSYNC:   return VSYNC_LINES;
      VBP:     return V_BP_LINES;
      ACTIVE:  return V_ACTIVE;
      VFP:     return V_FP_LINES;
      default: return 1;
    endcase
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state_q;
    h_nxt     = h_q;
    line_nxt  = line_q;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_nxt = VSYNC;
          h_nxt     = '0;
          line_nxt  = '0;
        end
      end
      default: begin
        if (32'(h_q) == 32'(LINE_PCLKS - 1)) begin
          h_nxt    = '0;
          line_nxt = line_q + LINE_W'(1);
          if (32'(line_q) == 32'(state_lines(state_q) - 1)) begin
            line_nxt = '0;
            // Zero-length blanking regions are skipped entirely.
            case (state_q)
              VSYNC:   state_nxt = (V_BP_LINES > 0) ? VBP : ACTIVE;
              VBP:     state_nxt = ACTIVE;
              ACTIVE:  begin
                if (V_FP_LINES > 0) state_nxt = VFP;
                else                frame_end = 1'b1;
              end
              default: frame_end = 1'b1;
            endcase
            if (frame_end) state_nxt = en_i ? VSYNC : IDLE;
          end
        end else begin
          h_nxt = h_q + H_W'(1);
        end
      end
    endcase

    // Outputs are decoded from the next-state values and registered at the pclk falling edge.
    href_nxt = (state_nxt == ACTIVE) && (32'(h_nxt) < 32'(2 * H_ACTIVE));
    x_f      = 10'(h_nxt >> 1);
    y_f      = 6'(line_nxt);
    pix      = {y_f, x_f};
`ifdef CMOS_DVP_GEN_FRAME_CNT_EN
    if ((state_nxt == ACTIVE) && (line_nxt == '0) && (h_nxt < H_W'(2))) pix = frame_cnt_q;
`endif
    data_nxt = '0;
    if (href_nxt) data_nxt = h_nxt[0] ? pix[7:0] : pix[15:8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cmos_pclk    <= 1'b0;
      cmos_vsyn    <= 1'b0;
      cmos_href    <= 1'b0;
      cmos_data    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      state_q      <= IDLE;
      h_q          <= '0;
      line_q       <= '0;
`ifdef CMOS_DVP_GEN_FRAME_CNT_EN
      frame_cnt_q  <= '0;
`endif
    end else begin
      cmos_pclk    <= ~cmos_pclk;
      frame_done_o <= 1'b0;
      // pclk is high now, so this edge takes it 1->0: the only cycle other outputs may move.
      if (cmos_pclk) begin
        state_q      <= state_nxt;
        h_q          <= h_nxt;
        line_q       <= line_nxt;
        frame_done_o <= frame_end;
        busy_o       <= (state_nxt != IDLE);
        cmos_vsyn    <= (state_nxt == VSYNC);
        cmos_href    <= href_nxt;
        cmos_data    <= data_nxt;
`ifdef CMOS_DVP_GEN_FRAME_CNT_EN
        if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cmos_dvp_gen.sv
// Bench for cmos_dvp_gen: lockstep frame model plus directed timing scenarios on a small frame geometry.
module tb_cmos_dvp_gen;

  localparam int HA = 4, VA = 3, HB = 2, VS = 1, VBP = 1, VFP = 1;
  localparam int L       = 2 * HA + HB;
  localparam int FRAME_P = (VS + VBP + VA + VFP) * L;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en_i = 1'b0;
  logic       cmos_pclk, cmos_vsyn, cmos_href, busy_o, frame_done_o;
  logic [7:0] cmos_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: frame-relative pclk index, everything else derived arithmetically.
  bit m_pclk, m_busy, m_done;
  int m_p, m_frames;

  cmos_dvp_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BP_LINES(VBP), .V_FP_LINES(VFP)
  ) dut (
    .CLK(CLK), .RST(RST), .en_i(en_i),
    .cmos_pclk(cmos_pclk), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [12:0] model_out();
    int line, h, y, x, pix;
    logic vs, hr;
    logic [7:0] d;
    vs = 1'b0; hr = 1'b0; d = 8'h00;
    if (m_busy) begin
      line = m_p / L;
      h    = m_p % L;
      vs   = (line < VS);
      y    = line - (VS + VBP);
      if (y >= 0 && y < VA && h < 2 * HA) begin
        hr  = 1'b1;
        x   = h / 2;
        pix = (y % 64) * 1024 + (x % 1024);
`ifdef CMOS_DVP_GEN_FRAME_CNT_EN
        if (x == 0 && y == 0) pix = m_frames % 65536;
`endif
        d = (h % 2 == 1) ? 8'(pix % 256) : 8'(pix / 256);
      end
    end
    return {m_pclk, vs, hr, d, m_busy, m_done};
  endfunction

  task automatic model_update(input logic en, input logic rst);
    bit fall;
    if (rst) begin
      m_pclk = 0; m_busy = 0; m_done = 0; m_p = 0; m_frames = 0;
    end else begin
      fall   = m_pclk;
      m_pclk = ~m_pclk;
      m_done = 0;
      if (fall) begin
        if (m_busy) begin
          m_p++;
          if (m_p == FRAME_P) begin
            m_done = 1;
            m_frames++;
            m_p = 0;
            if (!en) m_busy = 0;
          end
        end else if (en) begin
          m_busy = 1;
          m_p    = 0;
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic rst);
    logic [12:0] got, exp;
    en_i = en;
    RST  = rst;
    @(posedge CLK);
    model_update(en, rst);
    @(negedge CLK);
    cyc++;
    got = {cmos_pclk, cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o};
    exp = model_out();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL lockstep cyc=%0d got{pclk,vsyn,href,data,busy,done}=%h want=%h", cyc, got, exp);
    end
  endtask

  task automatic test_reset();
    logic prev;
    repeat (5) step(1'b0, 1'b1);
    n_cmp++;
    if ({cmos_pclk, cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_values got=%h want=0", {cmos_pclk, cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o});
    end
    prev = cmos_pclk;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (cmos_pclk !== ~prev || {cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o} !== 12'h0) begin
        n_bad++;
        $display("FAIL idle_toggle i=%0d pclk=%b prev=%b others=%h want others=0", i, cmos_pclk, prev,
                 {cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o});
      end
      prev = cmos_pclk;
    end
  endtask

  task automatic test_vsync_and_line();
    int n, vs_len, gap;
    logic [7:0] line1 [8];
    logic [8:0] caps [$];
    line1 = '{8'h04, 8'h00, 8'h04, 8'h01, 8'h04, 8'h02, 8'h04, 8'h03};
    n = 0;
    do begin step(1'b1, 1'b0); n++; end while (busy_o !== 1'b1 && n < 4);
    n_cmp++;
    if (busy_o !== 1'b1 || cmos_vsyn !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_start busy=%b vsyn=%b want 1 1", busy_o, cmos_vsyn);
    end
    vs_len = 0;
    while (cmos_vsyn === 1'b1 && vs_len < 100) begin vs_len++; step(1'b1, 1'b0); end
    n_cmp++;
    if (vs_len != 2 * VS * L) begin
      n_bad++;
      $display("FAIL vsync_width got=%0d CLK want=%0d", vs_len, 2 * VS * L);
    end
    gap = 0;
    while (cmos_href !== 1'b1 && gap < 100) begin gap++; step(1'b1, 1'b0); end
    n_cmp++;
    if (gap != 2 * VBP * L) begin
      n_bad++;
      $display("FAIL vbp_gap got=%0d CLK want=%0d", gap, 2 * VBP * L);
    end
    n = 0;
    while (caps.size() < 2 * L && n < 200) begin
      step(1'b1, 1'b0);
      n++;
      if (cmos_pclk === 1'b1) caps.push_back({cmos_href, cmos_data});
    end
    for (int i = 0; i < L; i++) begin
      logic [8:0] want;
      want = (i < 2 * HA) ? {1'b1, line1[i]} : 9'h000;
      n_cmp++;
      if (caps.size() <= L + i || caps[L + i] !== want) begin
        n_bad++;
        $display("FAIL line1_byte i=%0d got{href,data}=%h want=%h", i,
                 (caps.size() > L + i) ? caps[L + i] : 9'h1ff, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int n;
    n = 0;
    while (t.size() < 2 && n < 400) begin
      step(1'b1, 1'b0);
      n++;
      if (frame_done_o === 1'b1) begin
        t.push_back(cyc);
        n_cmp++;
        if (cmos_vsyn !== 1'b1 || busy_o !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_vsync_at_done vsyn=%b busy=%b want 1 1", cmos_vsyn, busy_o);
        end
        step(1'b1, 1'b0);
        n++;
        n_cmp++;
        if (frame_done_o !== 1'b0) begin
          n_bad++;
          $display("FAIL done_width got=%b want 0 one CLK after pulse", frame_done_o);
        end
      end
    end
    n_cmp++;
    if (t.size() != 2 || t[1] - t[0] != 2 * FRAME_P) begin
      n_bad++;
      $display("FAIL done_spacing pulses=%0d spacing=%0d want 2 pulses %0d apart", t.size(),
               (t.size() == 2) ? t[1] - t[0] : -1, 2 * FRAME_P);
    end
  endtask

  task automatic test_en_drop();
    int n, pulses, late_vs;
    n = 0;
    while (cmos_href !== 1'b1 && n < 200) begin step(1'b1, 1'b0); n++; end
    pulses = 0;
    late_vs = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0);
      if (frame_done_o === 1'b1) pulses++;
      if (pulses > 0 && cmos_vsyn === 1'b1) late_vs++;
    end
    n_cmp++;
    if (pulses != 1 || late_vs != 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL en_drop pulses=%0d vsyn_after=%0d busy=%b want 1 0 0", pulses, late_vs, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (cmos_href !== 1'b1 && n < 200) begin step(1'b1, 1'b0); n++; end
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_cmp++;
    if ({cmos_pclk, cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_mid got=%h want=0", {cmos_pclk, cmos_vsyn, cmos_href, cmos_data, busy_o, frame_done_o});
    end
    repeat (10) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic en;
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      step(en, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    m_pclk = 0; m_busy = 0; m_done = 0; m_p = 0; m_frames = 0;
    @(negedge CLK);
    test_reset();
    test_vsync_and_line();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
